// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath:
// opcode and memory handshake in, datapath strobes/selects and state out.
interface multicycle_ctrl_if;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  logic [OP_W-1:0]    op;
  logic               mem_ready;
  logic               pcwrite;
  logic               pcwritecond;
  logic               iord;
  logic               memread;
  logic               memwrite;
  logic               irwrite;
  logic               memtoreg;
  logic               regdst;
  logic               regwrite;
  logic               alusrca;
  logic               zext;
  logic [1:0]         alusrcb;
  logic [1:0]         pcsource;
  logic               aluop1;
  logic               aluop0;
  logic               instr_done;
  logic               illegal;
  logic [STATE_W-1:0] state;

  // Controller side
  modport master (
    input  op, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, zext, alusrcb, pcsource, aluop1, aluop0,
           instr_done, illegal, state
  );

  // Datapath side
  modport slave (
    output op, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, zext, alusrcb, pcsource, aluop1, aluop0,
           instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-style main controller for a multicycle MIPS-like datapath
// (lw/sw/R-type/beq/ori/j) with memory wait states.
module multicycle_ctrl #(
  parameter int unsigned USE_READY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
    MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
    ALUWB  = 4'd8,  BRANCH = 4'd9,  ORIEX  = 4'd10, ORIWB  = 4'd11,
    JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q, state_d;
  logic       ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, zext, instr_done, illegal;
  logic [1:0] alusrcb, pcsource, aluop;

  // With USE_READY=0 every memory access completes in one cycle
  assign ready = (USE_READY != 0) ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    zext        = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    alusrcb     = 2'b00;
    pcsource    = 2'b00;
    aluop       = 2'b00;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = ready;
        pcwrite = ready;
        if (ready) state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        unique case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ORI:       state_d = ORIEX;
          OP_J:         state_d = JUMP;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (ready) state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = ready;
        if (ready) state_d = FETCH;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
        instr_done  = 1'b1;
        state_d     = FETCH;
      end
      ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        zext    = 1'b1;
        aluop   = 2'b11;
        state_d = ORIWB;
      end
      ORIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        pcwrite    = 1'b1;
        pcsource   = 2'b10;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      // Codes 13-15 are unreachable; recover quietly into FETCH
      default: state_d = FETCH;
    endcase
  end

  assign bus.pcwrite     = pcwrite;
  assign bus.pcwritecond = pcwritecond;
  assign bus.iord        = iord;
  assign bus.memread     = memread;
  assign bus.memwrite    = memwrite;
  assign bus.irwrite     = irwrite;
  assign bus.memtoreg    = memtoreg;
  assign bus.regdst      = regdst;
  assign bus.regwrite    = regwrite;
  assign bus.alusrca     = alusrca;
  assign bus.zext        = zext;
  assign bus.alusrcb     = alusrcb;
  assign bus.pcsource    = pcsource;
  assign bus.aluop1      = aluop[1];
  assign bus.aluop0      = aluop[0];
  assign bus.instr_done  = instr_done;
  assign bus.illegal     = illegal;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level model of the
// state walk and per-state control word, checked every cycle at negedge.
module tb_multicycle_ctrl;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
    S_MEMADR = 4'd3, S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6,
    S_EXEC = 4'd7, S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_ORIEX = 4'd10,
    S_ORIWB = 4'd11, S_JUMP = 4'd12;

  typedef struct packed {
    logic pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic memtoreg, regdst, regwrite, alusrca, zext;
    logic [1:0] alusrcb, pcsource;
    logic aluop1, aluop0, instr_done, illegal;
  } ctrl_t;

  logic clk = 1'b0;
  logic rst_n;
  multicycle_ctrl_if ifc ();

  multicycle_ctrl #(.USE_READY(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.master)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic       exp_valid = 1'b0;
  logic [3:0] exp_state = S_IDLE;
  logic [3:0] st_log [$];
  int         done_cnt = 0;

  function automatic ctrl_t dut_ctrl();
    ctrl_t c;
    c.pcwrite = ifc.pcwrite;   c.pcwritecond = ifc.pcwritecond;
    c.iord = ifc.iord;         c.memread = ifc.memread;
    c.memwrite = ifc.memwrite; c.irwrite = ifc.irwrite;
    c.memtoreg = ifc.memtoreg; c.regdst = ifc.regdst;
    c.regwrite = ifc.regwrite; c.alusrca = ifc.alusrca;
    c.zext = ifc.zext;         c.alusrcb = ifc.alusrcb;
    c.pcsource = ifc.pcsource; c.aluop1 = ifc.aluop1;
    c.aluop0 = ifc.aluop0;     c.instr_done = ifc.instr_done;
    c.illegal = ifc.illegal;
    return c;
  endfunction

  function automatic logic legal_op(input logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                     6'b001101, 6'b000010};
  endfunction

  // Control word each state must present, written straight from the state table
  function automatic ctrl_t model(input logic [3:0] s, input logic [5:0] o,
                                  input logic mr);
    ctrl_t c = '0;
    case (s)
      S_FETCH:  begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcwrite = mr; end
      S_DECODE: begin c.alusrcb = 2'b11; c.illegal = !legal_op(o); end
      S_MEMADR: begin c.alusrca = 1; c.alusrcb = 2'b10; end
      S_MEMRD:  begin c.memread = 1; c.iord = 1; end
      S_MEMWB:  begin c.memtoreg = 1; c.regwrite = 1; c.instr_done = 1; end
      S_MEMWR:  begin c.memwrite = 1; c.iord = 1; c.instr_done = mr; end
      S_EXEC:   begin c.alusrca = 1; c.aluop1 = 1; end
      S_ALUWB:  begin c.regdst = 1; c.regwrite = 1; c.instr_done = 1; end
      S_BRANCH: begin c.alusrca = 1; c.aluop0 = 1; c.pcwritecond = 1;
                      c.pcsource = 2'b01; c.instr_done = 1; end
      S_ORIEX:  begin c.alusrca = 1; c.alusrcb = 2'b10; c.zext = 1;
                      c.aluop1 = 1; c.aluop0 = 1; end
      S_ORIWB:  begin c.regwrite = 1; c.instr_done = 1; end
      S_JUMP:   begin c.pcwrite = 1; c.pcsource = 2'b10; c.instr_done = 1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Per-cycle compare of DUT state and control word against the model
  task automatic compare_loop();
    ctrl_t got, want;
    forever begin
      @(negedge clk);
      if (exp_valid && rst_n) begin
        got  = dut_ctrl();
        want = model(exp_state, ifc.op, ifc.mem_ready);
        n_tests++;
        if (got !== want || ifc.state !== exp_state) begin
          n_fail++;
          $display("FAIL cycle t=%0t: state %0d ctrl %h expected state %0d ctrl %h",
                   $time, ifc.state, got, exp_state, want);
        end
        st_log.push_back(ifc.state);
        if (ifc.instr_done) done_cnt++;
      end
    end
  endtask

  // One clock cycle in an expected state with the given inputs
  task automatic step(input logic [3:0] s, input logic mr, input logic [5:0] o);
    ifc.op        = o;
    ifc.mem_ready = mr;
    exp_state     = s;
    exp_valid     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  // Whole instruction from FETCH; op is garbage outside DECODE/MEMADR
  task automatic run_instr(input logic [5:0] o, input int fw, input int mw);
    for (int i = 0; i < fw; i++) step(S_FETCH, 1'b0, junk());
    step(S_FETCH, 1'b1, junk());
    step(S_DECODE, rb(), o);
    case (o)
      6'b100011: begin
        step(S_MEMADR, rb(), o);
        for (int i = 0; i < mw; i++) step(S_MEMRD, 1'b0, junk());
        step(S_MEMRD, 1'b1, junk());
        step(S_MEMWB, rb(), junk());
      end
      6'b101011: begin
        step(S_MEMADR, rb(), o);
        for (int i = 0; i < mw; i++) step(S_MEMWR, 1'b0, junk());
        step(S_MEMWR, 1'b1, junk());
      end
      6'b000000: begin step(S_EXEC, rb(), junk()); step(S_ALUWB, rb(), junk()); end
      6'b000100: step(S_BRANCH, rb(), junk());
      6'b001101: begin step(S_ORIEX, rb(), junk()); step(S_ORIWB, rb(), junk()); end
      6'b000010: step(S_JUMP, rb(), junk());
      default: ;
    endcase
  endtask

  function automatic logic seq_is(input logic [3:0] w [$]);
    if (st_log.size() != w.size()) return 1'b0;
    foreach (w[i]) if (st_log[i] !== w[i]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    logic [3:0] w [$];
    rst_n         = 1'b0;
    ifc.op        = 6'b000000;
    ifc.mem_ready = 1'b0;
    fork compare_loop(); join_none

    repeat (2) @(negedge clk);
    check("reset_state", 32'(ifc.state), 32'(S_IDLE));
    check("reset_ctrl", 32'(dut_ctrl()), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // R-type, no waits: 1,2,7,8 then FETCH
    st_log.delete(); done_cnt = 0;
    run_instr(6'b000000, 0, 0);
    w = '{4'd1, 4'd2, 4'd7, 4'd8};
    check("rtype_seq", 32'(seq_is(w)), 32'd1);
    check("rtype_done_pulses", 32'(done_cnt), 32'd1);

    // lw with two MEMRD waits: MEMRD held 3 cycles
    st_log.delete(); done_cnt = 0;
    run_instr(6'b100011, 0, 2);
    w = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5};
    check("lw_wait_seq", 32'(seq_is(w)), 32'd1);
    check("lw_done_pulses", 32'(done_cnt), 32'd1);

    st_log.delete();
    run_instr(6'b000100, 0, 0);
    check("beq_cycles", 32'(st_log.size()), 32'd3);
    run_instr(6'b001101, 0, 0);
    run_instr(6'b000010, 0, 0);

    st_log.delete(); done_cnt = 0;
    run_instr(6'b101011, 0, 1);
    check("sw_cycles_1wait", 32'(st_log.size()), 32'd5);
    check("sw_done_pulses", 32'(done_cnt), 32'd1);

    // Illegal opcode: DECODE straight back to FETCH, no done pulse
    st_log.delete(); done_cnt = 0;
    run_instr(6'b111111, 0, 0);
    check("illegal_cycles", 32'(st_log.size()), 32'd2);
    check("illegal_no_done", 32'(done_cnt), 32'd0);

    run_instr(6'b100011, 1, 0);
    run_instr(6'b101011, 0, 0);
    run_instr(6'b010101, 2, 0);
    run_instr(6'b000000, 2, 0);

    // Reset asserted mid-MEMWR while memory is stalled
    run_instr(6'b111110, 0, 0);
    step(S_FETCH, 1'b1, junk());
    step(S_DECODE, 1'b1, 6'b101011);
    step(S_MEMADR, 1'b1, 6'b101011);
    step(S_MEMWR, 1'b0, junk());
    ifc.mem_ready = 1'b0;
    #1;
    check("memwr_stall_memwrite", 32'(ifc.memwrite), 32'd1);
    exp_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("async_rst_memwrite", 32'(ifc.memwrite), 32'd0);
    check("async_rst_state", 32'(ifc.state), 32'(S_IDLE));
    @(negedge clk);
    check("rst_hold_ctrl", 32'(dut_ctrl()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    st_log.delete();
    run_instr(6'b000000, 0, 0);
    check("post_rst_first", 32'(st_log[0]), 32'(S_FETCH));
    step(S_FETCH, 1'b1, junk());
    exp_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter USE_READY, default 1; 1 = honour mem_ready, 0 = treat mem_ready as constant 1.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port op  input  6  opcode field of the instruction register.
REQ-005 SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-006 SHALL have ports pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca, zext  output  1 each  datapath strobes/selects.
REQ-007 SHALL have ports alusrcb, pcsource  output  2 each  ALU operand B select (00 reg, 01 const 4, 10 ext imm, 11 imm<<2), PC source (00 ALU, 01 ALUOut, 10 jump target).
REQ-008 SHALL have ports aluop1, aluop0  output  1 each  ALU-control class: 00 add, 01 sub, 10 R-type funct, 11 OR.
REQ-009 SHALL have ports instr_done, illegal  output  1 each  one-cycle pulses; state  output  4  current state code.

Function
REQ-010 SHALL be a Moore FSM; outputs decode from the state register only, except FETCH pcwrite/irwrite and the wait-state exits, which are qualified by mem_ready.
REQ-011 SHALL use the state codes IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ORIEX=10, ORIWB=11, JUMP=12.
REQ-012 SHALL deassert every output not listed for a state (0 / 00).
REQ-013 IDLE: all outputs 0; next FETCH unconditionally.
REQ-014 FETCH: memread=1, alusrcb=01, aluop=00, pcsource=00, irwrite=pcwrite=mem_ready; stay while mem_ready=0, else DECODE.
REQ-015 DECODE: alusrcb=11, aluop=00; next by op: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001101 -> ORIEX, 000010 -> JUMP, any other -> FETCH with illegal=1 this cycle.
REQ-016 MEMADR: alusrca=1, alusrcb=10, aluop=00; op 100011 -> MEMRD, else MEMWR.
REQ-017 MEMRD: memread=1, iord=1; stay while mem_ready=0, else MEMWB.
REQ-018 MEMWB: memtoreg=1, regwrite=1, regdst=0, instr_done=1; next FETCH.
REQ-019 MEMWR: memwrite=1, iord=1; stay while mem_ready=0; on mem_ready=1 instr_done=1, next FETCH.
REQ-020 EXEC: alusrca=1, alusrcb=00, aluop=10; next ALUWB. ALUWB: regdst=1, regwrite=1, instr_done=1; next FETCH.
REQ-021 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01, instr_done=1; next FETCH.
REQ-022 ORIEX: alusrca=1, alusrcb=10, zext=1, aluop=11; next ORIWB. ORIWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1; next FETCH.
REQ-023 JUMP: pcwrite=1, pcsource=10, instr_done=1; next FETCH.
REQ-024 Unused state codes 13-15 SHALL drive all outputs 0 and go to FETCH next cycle.
REQ-025 Cycle counts with zero wait: R-type/ori 4, beq/j 3, sw 4, lw 5; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.
REQ-026 op SHALL be sampled only in DECODE and MEMADR; changes elsewhere have no effect.

Reset
REQ-027 rst_n=0 SHALL force state=IDLE immediately (asynchronous), all outputs 0, including mid-wait in MEMRD/MEMWR.
REQ-028 First rising edge with rst_n=1 SHALL move IDLE -> FETCH.

Verification
REQ-029 Reset release, op=000000, mem_ready=1 -> states 0,1,2,7,8,1; regdst=regwrite=1 in state 8; instr_done high 1 cycle.
REQ-030 op=100011, mem_ready low 2 cycles in MEMRD -> 4 held 3 cycles, memread=iord=1 throughout, then 5 with memtoreg=1.
REQ-031 op=000100 -> DECODE aluop=00 alusrcb=11, BRANCH aluop=01 pcwritecond=1 pcsource=01, back to FETCH after 3 cycles.
REQ-032 op=001101 -> ORIEX aluop1=aluop0=1, zext=1; ORIWB regwrite=1 regdst=0.
REQ-033 op=111111 in DECODE -> illegal=1 one cycle, next state FETCH, regwrite/memwrite never asserted.
REQ-034 rst_n low mid-MEMWR with mem_ready=0 -> memwrite drops same cycle, state=0; after release sequence restarts at FETCH.
